// File: rtl/pipe_stage_reg.sv
`timescale 1ns/1ps
// Pipeline stage register with valid/ready handshake, optional skid entry, synchronous flush and a stall counter.
// Latency: one cycle from accept to out_valid; one entry per cycle while out_ready is high.
// Backpressure: SKID=1 absorbs one extra entry behind a registered in_ready; SKID=0 uses in_ready = !out_valid || out_ready.
module pipe_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 4,
    parameter int CTRL_W   = 5,
    parameter int ADDR_W   = 5,
    parameter int SKID     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [ADDR_W-1:0]          in_waddr,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [ADDR_W-1:0]          out_waddr,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [1:0]                 occupancy,
    output logic [15:0]                stall_cnt
);

    localparam int DW = NUM_DATA * DATA_W;

    // Main entry drives the outputs; the skid entry only holds the one
    // instruction accepted during the first cycle of back-pressure.
    logic              main_vld_q,   main_vld_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [ADDR_W-1:0] main_waddr_q, main_waddr_d;
    logic [DW-1:0]     main_data_q,  main_data_d;
    logic              skid_vld_q,   skid_vld_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [ADDR_W-1:0] skid_waddr_q, skid_waddr_d;
    logic [DW-1:0]     skid_data_q,  skid_data_d;
    logic              in_rdy_q,     in_rdy_d;
    logic [15:0]       stall_cnt_q,  stall_cnt_d;

    logic pop;
    logic acc;

    assign pop      = main_vld_q && out_ready;
    // With a skid entry the upstream sees a pure flop, so no ready path
    // runs combinationally from downstream to upstream.
    assign in_ready = (SKID != 0) ? in_rdy_q : (!main_vld_q || out_ready);
    assign acc      = in_valid && in_ready;

    // Next-state selection for both entries; flush overrides everything
    // except the stall counter and leaves the data registers untouched.
    always_comb begin
        main_vld_d   = main_vld_q;
        main_ctrl_d  = main_ctrl_q;
        main_waddr_d = main_waddr_q;
        main_data_d  = main_data_q;
        skid_vld_d   = skid_vld_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_waddr_d = skid_waddr_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // in_ready is low while the skid is full, so only a refill can happen here.
            if (pop) begin
                main_vld_d   = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_waddr_d = skid_waddr_q;
                main_data_d  = skid_data_q;
                skid_vld_d   = 1'b0;
            end
        end else if (!main_vld_q || pop) begin
            main_vld_d = acc;
            if (acc) begin
                main_ctrl_d  = in_ctrl;
                main_waddr_d = in_waddr;
                main_data_d  = in_data;
            end
        end else if (acc) begin
            // Main is held by back-pressure; only reachable with SKID=1.
            skid_vld_d   = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_waddr_d = in_waddr;
            skid_data_d  = in_data;
        end

        in_rdy_d = !skid_vld_d;
    end

    // Stall counter: one count per cycle the main entry waits on downstream, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_vld_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q   <= 1'b0;
            main_ctrl_q  <= '0;
            main_waddr_q <= '0;
            main_data_q  <= '0;
            skid_vld_q   <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_waddr_q <= '0;
            skid_data_q  <= '0;
            in_rdy_q     <= 1'b1;
            stall_cnt_q  <= 16'd0;
        end else begin
            main_vld_q   <= main_vld_d;
            main_ctrl_q  <= main_ctrl_d;
            main_waddr_q <= main_waddr_d;
            main_data_q  <= main_data_d;
            skid_vld_q   <= skid_vld_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_waddr_q <= skid_waddr_d;
            skid_data_q  <= skid_data_d;
            in_rdy_q     <= in_rdy_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Bubbles must never carry a live write or memory enable downstream.
    assign out_valid = main_vld_q;
    assign out_ctrl  = main_vld_q ? main_ctrl_q  : '0;
    assign out_waddr = main_vld_q ? main_waddr_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
`timescale 1ns/1ps
// Testbench for pipe_stage_reg: SKID=1 instance (a_*) and SKID=0 instance (b_*).
// Directed stimulus; a negedge monitor per instance pops expected entries from a queue.
// Directed checks run one time unit after each rising edge.
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int ND = 4;
    localparam int CW = 5;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [CW-1:0]  a_in_ctrl, a_out_ctrl;
    logic [AW-1:0]  a_in_waddr, a_out_waddr;
    logic [ND*DW-1:0] a_in_data, a_out_data;
    logic [1:0]     a_occ;
    logic [15:0]    a_stall;

    logic           b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [CW-1:0]  b_in_ctrl, b_out_ctrl;
    logic [AW-1:0]  b_in_waddr, b_out_waddr;
    logic [ND*DW-1:0] b_in_data, b_out_data;
    logic [1:0]     b_occ;
    logic [15:0]    b_stall;

    pipe_stage_reg #(.DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW), .ADDR_W(AW), .SKID(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl),
        .in_waddr(a_in_waddr), .in_data(a_in_data), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
        .out_waddr(a_out_waddr), .out_data(a_out_data), .occupancy(a_occ),
        .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW), .ADDR_W(AW), .SKID(0)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl),
        .in_waddr(b_in_waddr), .in_data(b_in_data), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_waddr(b_out_waddr), .out_data(b_out_data), .occupancy(b_occ),
        .stall_cnt(b_stall)
    );

    typedef struct packed {
        logic [CW-1:0]    ctrl;
        logic [AW-1:0]    waddr;
        logic [ND*DW-1:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   a_pops = 0;
    int   b_pops = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    bit b_ordy     [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit b_irdy_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int bn = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ND*DW-1:0] mk(input logic [31:0] l0);
        return {l0 + 32'h3000, l0 + 32'h2000, l0 + 32'h1000, l0};
    endfunction

    task automatic drive_a(input logic v, input logic [31:0] l0, input logic [CW-1:0] c, input logic [AW-1:0] w);
        a_in_valid = v;
        a_in_data  = mk(l0);
        a_in_ctrl  = c;
        a_in_waddr = w;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / monitor for the SKID=1 instance.
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                a_pops++;
                if (qa.size() == 0) begin
                    check("a_pop_unexpected", 160'(1), 160'(0));
                end else begin
                    ea = qa.pop_front();
                    check("a_pop_entry", 160'({a_out_ctrl, a_out_waddr, a_out_data}), 160'(ea));
                end
            end
            if (a_flush) begin
                qa.delete();
            end else if (a_in_valid && a_in_ready) begin
                qa.push_back('{ctrl: a_in_ctrl, waddr: a_in_waddr, data: a_in_data});
            end
        end
    end

    // Scoreboard / monitor for the SKID=0 instance.
    always @(negedge clk) begin
        if (rst) begin
            qb.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                b_pops++;
                if (qb.size() == 0) begin
                    check("b_pop_unexpected", 160'(1), 160'(0));
                end else begin
                    eb = qb.pop_front();
                    check("b_pop_entry", 160'({b_out_ctrl, b_out_waddr, b_out_data}), 160'(eb));
                end
            end
            if (b_flush) begin
                qb.delete();
            end else if (b_in_valid && b_in_ready) begin
                qb.push_back('{ctrl: b_in_ctrl, waddr: b_in_waddr, data: b_in_data});
            end
        end
    end

    initial begin
        a_in_valid = 1'b0; a_in_ctrl = '0; a_in_waddr = '0; a_in_data = '0;
        a_flush = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_ctrl = '0; b_in_waddr = '0; b_in_data = '0;
        b_flush = 1'b0; b_out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 160'(a_out_valid), 160'(0));
        check("rst_out_ctrl",  160'(a_out_ctrl),  160'(0));
        check("rst_out_waddr", 160'(a_out_waddr), 160'(0));
        check("rst_out_data",  160'(a_out_data),  160'(0));
        check("rst_occupancy", 160'(a_occ),       160'(0));
        check("rst_stall_cnt", 160'(a_stall),     160'(0));
        check("rst_in_ready",  160'(a_in_ready),  160'(1));
        check("rst_b_in_ready", 160'(b_in_ready), 160'(1));

        // Stream of four entries with no back-pressure
        a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_a(1'b1, 32'(i), 5'b00010, 5'd3);
            cyc();
            check("t1_out_valid", 160'(a_out_valid), 160'(1));
            check("t1_lane0",     160'(a_out_data[31:0]), 160'(i));
            check("t1_ctrl",      160'(a_out_ctrl), 160'(5'b00010));
            check("t1_waddr",     160'(a_out_waddr), 160'(3));
            check("t1_occupancy", 160'(a_occ), 160'(1));
        end
        a_in_valid = 1'b0;
        cyc();
        check("t1_drain_valid", 160'(a_out_valid), 160'(0));
        check("t1_drain_occ",   160'(a_occ), 160'(0));
        check("t1_stall_cnt",   160'(a_stall), 160'(0));

        // SKID=1 back-pressure: A in main, B in skid
        a_out_ready = 1'b0;
        drive_a(1'b1, 32'h11, 5'b10101, 5'd17);
        cyc();
        check("t2_occ_a",   160'(a_occ), 160'(1));
        check("t2_rdy_a",   160'(a_in_ready), 160'(1));
        check("t2_stall_a", 160'(a_stall), 160'(0));
        drive_a(1'b1, 32'h22, 5'b01010, 5'd18);
        cyc();
        check("t2_occ_b",   160'(a_occ), 160'(2));
        check("t2_rdy_b",   160'(a_in_ready), 160'(0));
        check("t2_stall_b", 160'(a_stall), 160'(1));
        a_in_valid = 1'b0;
        cyc();
        cyc();
        check("t2_hold_rdy",   160'(a_in_ready), 160'(0));
        check("t2_hold_occ",   160'(a_occ), 160'(2));
        check("t2_hold_stall", 160'(a_stall), 160'(3));
        check("t2_hold_lane0", 160'(a_out_data[31:0]), 160'(32'h11));
        a_out_ready = 1'b1;
        cyc();
        check("t2_pop1_lane0", 160'(a_out_data[31:0]), 160'(32'h22));
        check("t2_pop1_rdy",   160'(a_in_ready), 160'(1));
        check("t2_pop1_occ",   160'(a_occ), 160'(1));
        check("t2_pop1_stall", 160'(a_stall), 160'(3));
        cyc();
        check("t2_pop2_valid", 160'(a_out_valid), 160'(0));
        check("t2_pop2_rdy",   160'(a_in_ready), 160'(1));
        check("t2_pop2_occ",   160'(a_occ), 160'(0));

        // Flush with occupancy 2, in_valid high and a pop in the same cycle
        a_out_ready = 1'b0;
        drive_a(1'b1, 32'h55, 5'b11111, 5'd21);
        cyc();
        drive_a(1'b1, 32'h66, 5'b11110, 5'd22);
        cyc();
        check("t3_pre_occ",   160'(a_occ), 160'(2));
        check("t3_pre_stall", 160'(a_stall), 160'(4));
        a_out_ready = 1'b1;
        a_flush = 1'b1;
        drive_a(1'b1, 32'h77, 5'b11011, 5'd23);
        cyc();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        check("t3_valid", 160'(a_out_valid), 160'(0));
        check("t3_ctrl",  160'(a_out_ctrl), 160'(0));
        check("t3_waddr", 160'(a_out_waddr), 160'(0));
        check("t3_occ",   160'(a_occ), 160'(0));
        check("t3_rdy",   160'(a_in_ready), 160'(1));
        check("t3_stall", 160'(a_stall), 160'(4));
        check("t3_data_kept", 160'(a_out_data[31:0]), 160'(32'h55));

        // Flush and accept in the same cycle on an empty stage
        a_flush = 1'b1;
        drive_a(1'b1, 32'h88, 5'b00111, 5'd24);
        cyc();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        check("t3b_valid", 160'(a_out_valid), 160'(0));
        check("t3b_occ",   160'(a_occ), 160'(0));
        check("t3b_rdy",   160'(a_in_ready), 160'(1));
        check("t3b_data_kept", 160'(a_out_data[31:0]), 160'(32'h55));

        // SKID=0: constant in_valid, out_ready toggling
        b_in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b_out_ready = b_ordy[k];
            b_in_data   = mk(32'h0B0 + 32'(bn));
            b_in_ctrl   = 5'b01001;
            b_in_waddr  = 5'(bn + 7);
            #1;
            check("t4_in_ready", 160'(b_in_ready), 160'(b_irdy_exp[k]));
            if (b_in_ready) bn++;
            cyc();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        cyc();
        cyc();
        check("t4_pops",   160'(b_pops), 160'(3));
        check("t4_q_left", 160'(qb.size()), 160'(0));
        check("t4_stall",  160'(b_stall), 160'(2));

        // Stall counter saturation
        a_out_ready = 1'b0;
        drive_a(1'b1, 32'h99, 5'b00001, 5'd25);
        cyc();
        a_in_valid = 1'b0;
        repeat (65530) @(posedge clk);
        #1;
        check("t5_stall_fffe", 160'(a_stall), 160'(16'hFFFE));
        repeat (3) cyc();
        check("t5_stall_sat", 160'(a_stall), 160'(16'hFFFF));
        check("t5_lane0",     160'(a_out_data[31:0]), 160'(32'h99));

        // Asynchronous reset with occupancy 2
        drive_a(1'b1, 32'hAA, 5'b00100, 5'd26);
        cyc();
        a_in_valid = 1'b0;
        check("t6_pre_occ", 160'(a_occ), 160'(2));
        #2;
        rst = 1'b1;
        #1;
        check("t6_out_valid", 160'(a_out_valid), 160'(0));
        check("t6_out_ctrl",  160'(a_out_ctrl), 160'(0));
        check("t6_out_waddr", 160'(a_out_waddr), 160'(0));
        check("t6_out_data",  160'(a_out_data), 160'(0));
        check("t6_occ",       160'(a_occ), 160'(0));
        check("t6_stall",     160'(a_stall), 160'(0));
        check("t6_in_ready",  160'(a_in_ready), 160'(1));
        cyc();
        rst = 1'b0;
        a_out_ready = 1'b1;
        drive_a(1'b1, 32'h33, 5'b00011, 5'd9);
        cyc();
        a_in_valid = 1'b0;
        check("t6_post_valid", 160'(a_out_valid), 160'(1));
        check("t6_post_lane0", 160'(a_out_data[31:0]), 160'(32'h33));
        check("t6_post_stall", 160'(a_stall), 160'(0));
        cyc();
        check("t6_post_occ", 160'(a_occ), 160'(0));

        check("a_total_pops", 160'(a_pops), 160'(8));
        check("a_q_left",     160'(qa.size()), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
